regfile_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the APB-side 16x32 register file (word addresses 0x00..0x3C). It lets two requesters share the single register-file access port, for example the APB slave front end (port 0) and a debug/DMA engine (port 1). It selects one request at a time using round-robin, drives exactly one RegENABLE strobe per transaction and waits for RegREADY. It returns read data or an error to the winning requester, rejecting illegal addresses and timing out a stuck access.

---
 rtl/regfile_arbiter_if.sv | 57 +++++
 rtl/regfile_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Bundles both requester ports and the register-file access port of the arbiter.
// Pure wiring: adds no latency of its own.
// Requesters hold valid until their done pulse; the register file answers with RegREADY.
interface regfile_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    // Port 0 requester
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_done;
    logic                  req0_err;
    logic [DATA_WIDTH-1:0] req0_rdata;

    // Port 1 requester
    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_done;
    logic                  req1_err;
    logic [DATA_WIDTH-1:0] req1_rdata;

    // Register-file access port
    logic [ADDR_WIDTH-1:0] RegADDR;
    logic [DATA_WIDTH-1:0] RegWDATA;
    logic                  RegWRITE;
    logic                  RegENABLE;
    logic [DATA_WIDTH-1:0] RegRDATA;
    logic                  RegREADY;

    logic                  busy;

    // Arbiter side: drives completions and the register-file strobe
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_done, req1_err, req1_rdata,
        output RegADDR, RegWDATA, RegWRITE, RegENABLE,
        input  RegRDATA, RegREADY,
        output busy
    );

    // Environment side: requesters plus the register file itself
    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_done, req0_err, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_done, req1_err, req1_rdata,
        input  RegADDR, RegWDATA, RegWRITE, RegENABLE,
        output RegRDATA, RegREADY,
        input  busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-file port between two requesters.
// Latency: done 3 cycles after valid (legal), 2 (illegal address), TIMEOUT_CYCLES+2 (no RegREADY).
// Backpressure: requests hold valid until done; the register file stalls via RegREADY, bounded by a timeout.
module regfile_arbiter #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDR       = 'h0000_003C,
    parameter int unsigned           TIMEOUT_CYCLES = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    regfile_arbiter_if.master bus
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_q,        gnt_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;

    logic [ADDR_WIDTH-1:0] reg_addr_q,   reg_addr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q,  reg_wdata_d;
    logic                  reg_write_q,  reg_write_d;
    logic                  reg_enable_q, reg_enable_d;

    logic                  done0_q,      done0_d;
    logic                  err0_q,       err0_d;
    logic [DATA_WIDTH-1:0] rdata0_q,     rdata0_d;
    logic                  done1_q,      done1_d;
    logic                  err1_q,       err1_d;
    logic [DATA_WIDTH-1:0] rdata1_q,     rdata1_d;

    // Arbitration and completion helpers, all combinational
    logic                  elig0;
    logic                  elig1;
    logic                  pick;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_legal;
    logic                  cmp_vld;
    logic                  cmp_err;
    logic [DATA_WIDTH-1:0] cmp_rdata;

    // State and output registers; reset clears every output and favours port 0 on the first tie
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= '0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            reg_write_q  <= 1'b0;
            reg_enable_q <= 1'b0;
            done0_q      <= 1'b0;
            err0_q       <= 1'b0;
            rdata0_q     <= '0;
            done1_q      <= 1'b0;
            err1_q       <= 1'b0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            reg_write_q  <= reg_write_d;
            reg_enable_q <= reg_enable_d;
            done0_q      <= done0_d;
            err0_q       <= err0_d;
            rdata0_q     <= rdata0_d;
            done1_q      <= done1_d;
            err1_q       <= err1_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Next-state: round-robin grant in IDLE, single-cycle strobe, bounded wait, completion routing
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_write_d  = reg_write_q;
        reg_enable_d = 1'b0;
        done0_d      = 1'b0;
        err0_d       = err0_q;
        rdata0_d     = rdata0_q;
        done1_d      = 1'b0;
        err1_d       = err1_q;
        rdata1_d     = rdata1_q;
        cmp_vld      = 1'b0;
        cmp_err      = 1'b0;
        cmp_rdata    = '0;

        // A port still showing valid in its own done cycle is the tail of the
        // request just served, not a new one, so it must not compete.
        elig0 = bus.req0_valid & ~done0_q;
        elig1 = bus.req1_valid & ~done1_q;

        // On a tie the port that did not win last time goes first.
        pick      = (elig0 & elig1) ? ~last_grant_q : elig1;
        sel_write = pick ? bus.req1_write : bus.req0_write;
        sel_addr  = pick ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = pick ? bus.req1_wdata : bus.req0_wdata;
        sel_legal = (sel_addr <= MAX_ADDR) && (sel_addr[1:0] == 2'b00);

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    if (sel_legal) begin
                        reg_addr_d   = sel_addr;
                        reg_wdata_d  = sel_wdata;
                        reg_write_d  = sel_write;
                        reg_enable_d = 1'b1;
                        state_d      = ACCESS;
                    end else begin
                        // Illegal addresses never reach the register file.
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.RegREADY) begin
                    cmp_vld   = 1'b1;
                    cmp_rdata = reg_write_q ? '0 : bus.RegRDATA;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cmp_vld = 1'b1;
                    cmp_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                cmp_vld = 1'b1;
                cmp_err = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion goes only to the port that owns the transaction; the other
        // port keeps its previous err/rdata.
        if (cmp_vld) begin
            if (gnt_q) begin
                done1_d  = 1'b1;
                err1_d   = cmp_err;
                rdata1_d = cmp_rdata;
            end else begin
                done0_d  = 1'b1;
                err0_d   = cmp_err;
                rdata0_d = cmp_rdata;
            end
        end
    end

    assign bus.RegADDR    = reg_addr_q;
    assign bus.RegWDATA   = reg_wdata_q;
    assign bus.RegWRITE   = reg_write_q;
    assign bus.RegENABLE  = reg_enable_q;
    assign bus.req0_done  = done0_q;
    assign bus.req0_err   = err0_q;
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_done  = done1_q;
    assign bus.req1_err   = err1_q;
    assign bus.req1_rdata = rdata1_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int T     = 4;
    localparam int NEVER = 1000;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b1;

    regfile_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rif ();

    regfile_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ADDR(32'h0000_003C), .TIMEOUT_CYCLES(T)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .bus(rif.master)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Register file emulation: commits at the RegENABLE edge, answers after rf_delay WAIT cycles
    logic [31:0] rf_mem [16] = '{default: 32'h0};
    int          rf_delay = 0;
    int          rf_cnt;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rf_cnt       <= 0;
            rif.RegREADY <= 1'b0;
            rif.RegRDATA <= '0;
        end else begin
            rif.RegREADY <= 1'b0;
            if (rif.RegENABLE) begin
                if (rif.RegWRITE) rf_mem[rif.RegADDR[5:2]] <= rif.RegWDATA;
                rif.RegRDATA <= rf_mem[rif.RegADDR[5:2]];
                if (rf_delay == 0) begin
                    rif.RegREADY <= 1'b1;
                    rf_cnt       <= 0;
                end else if (rf_delay >= NEVER) begin
                    rf_cnt <= 0;
                end else begin
                    rf_cnt <= rf_delay;
                end
            end else if (rf_cnt > 0) begin
                rf_cnt <= rf_cnt - 1;
                if (rf_cnt == 1) rif.RegREADY <= 1'b1;
            end
        end
    end

    // Monitor: strobe and completion history, sampled away from the active edge
    int cyc        = 0;
    bit en_prev    = 1'b0;
    int en_consec  = 0;
    int done_both  = 0;
    int en_cyc_q[$];
    int done_port_q[$];
    int done_cyc_q[$];

    always @(negedge PCLK) begin
        cyc     <= cyc + 1;
        en_prev <= rif.RegENABLE;
        if (rif.RegENABLE) begin
            en_cyc_q.push_back(cyc);
            if (en_prev) en_consec <= en_consec + 1;
        end
        if (rif.req0_done && rif.req1_done) done_both <= done_both + 1;
        if (rif.req0_done) begin
            done_port_q.push_back(0);
            done_cyc_q.push_back(cyc);
        end
        if (rif.req1_done) begin
            done_port_q.push_back(1);
            done_cyc_q.push_back(cyc);
        end
    end

    // Behavioural model of register-file contents
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    function automatic logic [133:0] all_outs();
        return {rif.RegADDR, rif.RegWDATA, rif.RegWRITE, rif.RegENABLE,
                rif.req0_done, rif.req0_err, rif.req0_rdata,
                rif.req1_done, rif.req1_err, rif.req1_rdata};
    endfunction

    task automatic set_req(input int p, input bit v, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            rif.req0_valid = v; rif.req0_write = wr; rif.req0_addr = a; rif.req0_wdata = d;
        end else begin
            rif.req1_valid = v; rif.req1_write = wr; rif.req1_addr = a; rif.req1_wdata = d;
        end
    endtask

    // Raise a request now, wait (bounded) for its done; lat=-1 when it never completes
    task automatic port_req(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input bit hold, output bit err, output logic [31:0] rd, output int lat);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        err  = 1'b1;
        rd   = 32'hxxxx_xxxx;
        set_req(p, 1'b1, wr, a, d);
        while (!seen && n < 40) begin
            @(negedge PCLK);
            n++;
            if ((p == 0) ? rif.req0_done : rif.req1_done) begin
                seen = 1'b1;
                err  = (p == 0) ? rif.req0_err   : rif.req1_err;
                rd   = (p == 0) ? rif.req0_rdata : rif.req1_rdata;
            end
        end
        lat = seen ? n : -1;
        if (!hold) set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_reset();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        n_cmp++;
        if (all_outs() !== 134'h0) begin
            n_bad++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        n_cmp++;
        if (rif.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got=%b exp=0", rif.busy);
        end
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        n_cmp++;
        if ({rif.busy, rif.RegENABLE} !== 2'b00) begin
            n_bad++; $display("FAIL idle_after_reset got busy/en=%b exp=00", {rif.busy, rif.RegENABLE});
        end
    endtask

    task automatic test_write_read();
        bit e; logic [31:0] r; int l; int b_en;
        @(negedge PCLK);
        b_en = en_cyc_q.size();
        port_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, e, r, l);
        ref_mem[4] = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b exp=0", e); end
        n_cmp++; if (l !== 3) begin n_bad++; $display("FAIL wr_latency got=%0d exp=3", l); end
        n_cmp++;
        if (en_cyc_q.size() - b_en !== 1) begin
            n_bad++; $display("FAIL wr_strobes got=%0d exp=1", en_cyc_q.size() - b_en);
        end
        @(negedge PCLK);
        b_en = en_cyc_q.size();
        port_req(0, 1'b0, 32'h10, 32'h0, 1'b0, e, r, l);
        #1;
        n_cmp++; if (r !== ref_mem[4]) begin n_bad++; $display("FAIL rd_data got=%h exp=%h", r, ref_mem[4]); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rd_err got=%b exp=0", e); end
        n_cmp++; if (l !== 3) begin n_bad++; $display("FAIL rd_latency got=%0d exp=3", l); end
        n_cmp++;
        if (en_cyc_q.size() - b_en !== 1) begin
            n_bad++; $display("FAIL rd_strobes got=%0d exp=1", en_cyc_q.size() - b_en);
        end
    endtask

    task automatic test_back_to_back();
        int b_done; int b_en; int got; int exp;
        do_reset();
        b_done = done_port_q.size();
        b_en   = en_cyc_q.size();
        fork
            begin : br0
                bit e; logic [31:0] r; int l;
                for (int i = 0; i < 3; i++) begin
                    @(negedge PCLK);
                    port_req(0, 1'b1, 32'h04, 32'h11, 1'b0, e, r, l);
                    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL alt_p0_err[%0d] got=%b exp=0", i, e); end
                end
            end
            begin : br1
                bit e; logic [31:0] r; int l;
                for (int i = 0; i < 3; i++) begin
                    @(negedge PCLK);
                    port_req(1, 1'b1, 32'h08, 32'h22, 1'b0, e, r, l);
                    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL alt_p1_err[%0d] got=%b exp=0", i, e); end
                end
            end
        join
        ref_mem[1] = 32'h11;
        ref_mem[2] = 32'h22;
        #1;
        for (int k = 0; k < 6; k++) begin
            got = (b_done + k < done_port_q.size()) ? done_port_q[b_done + k] : -1;
            n_cmp++;
            if (got !== k % 2) begin n_bad++; $display("FAIL alt_order[%0d] got=%0d exp=%0d", k, got, k % 2); end
        end
        for (int k = 0; k < 5; k++) begin
            got = (b_en + k + 1 < en_cyc_q.size()) ? en_cyc_q[b_en + k + 1] : -1;
            exp = (b_done + k < done_cyc_q.size()) ? done_cyc_q[b_done + k] + 1 : -2;
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL alt_no_gap[%0d] got=%0d exp=%0d", k, got, exp); end
        end
    endtask

    task automatic test_illegal();
        bit e; logic [31:0] r; int l; int b_en;
        @(negedge PCLK);
        port_req(0, 1'b0, 32'h10, 32'h0, 1'b0, e, r, l);
        n_cmp++; if (r !== ref_mem[4]) begin n_bad++; $display("FAIL pre_illegal_rd got=%h exp=%h", r, ref_mem[4]); end
        @(negedge PCLK);
        b_en = en_cyc_q.size();
        port_req(1, 1'b0, 32'h40, 32'h0, 1'b0, e, r, l);
        #1;
        n_cmp++; if ({e, r} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL ill_p1 got err=%b rd=%h exp err=1 rd=0", e, r); end
        n_cmp++; if (l !== 2) begin n_bad++; $display("FAIL ill_p1_latency got=%0d exp=2", l); end
        n_cmp++;
        if (rif.req0_rdata !== ref_mem[4]) begin
            n_bad++; $display("FAIL p0_rdata_hold got=%h exp=%h", rif.req0_rdata, ref_mem[4]);
        end
        @(negedge PCLK);
        port_req(0, 1'b0, 32'h06, 32'h0, 1'b0, e, r, l);
        #1;
        n_cmp++; if ({e, r} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL ill_p0 got err=%b rd=%h exp err=1 rd=0", e, r); end
        n_cmp++; if (l !== 2) begin n_bad++; $display("FAIL ill_p0_latency got=%0d exp=2", l); end
        n_cmp++;
        if (en_cyc_q.size() !== b_en) begin
            n_bad++; $display("FAIL ill_strobes got=%0d exp=0", en_cyc_q.size() - b_en);
        end
    endtask

    task automatic test_timeout();
        bit e; logic [31:0] r; int l; int b_en;
        rf_delay = NEVER;
        @(negedge PCLK);
        b_en = en_cyc_q.size();
        port_req(0, 1'b0, 32'h00, 32'h0, 1'b0, e, r, l);
        #1;
        rf_delay = 0;
        n_cmp++; if ({e, r} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL tmo_result got err=%b rd=%h exp err=1 rd=0", e, r); end
        n_cmp++; if (l !== T + 2) begin n_bad++; $display("FAIL tmo_latency got=%0d exp=%0d", l, T + 2); end
        n_cmp++;
        if (en_cyc_q.size() - b_en !== 1) begin
            n_bad++; $display("FAIL tmo_strobes got=%0d exp=1", en_cyc_q.size() - b_en);
        end
    endtask

    task automatic test_reset_mid();
        int b_done;
        rf_delay = NEVER;
        @(negedge PCLK);
        set_req(1, 1'b1, 1'b0, 32'h0C, 32'h0);
        repeat (2) @(negedge PCLK);
        n_cmp++;
        if ({rif.busy, rif.RegENABLE} !== 2'b10) begin
            n_bad++; $display("FAIL mid_in_wait got busy/en=%b exp=10", {rif.busy, rif.RegENABLE});
        end
        b_done = done_port_q.size();
        #2 PRESETn = 1'b0;
        #1;
        n_cmp++;
        if ({all_outs(), rif.busy} !== 135'h0) begin
            n_bad++; $display("FAIL mid_async_clear got=%h exp=0", {all_outs(), rif.busy});
        end
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge PCLK);
        PRESETn  = 1'b1;
        rf_delay = 0;
        repeat (2) @(negedge PCLK);
        n_cmp++;
        if (done_port_q.size() !== b_done) begin
            n_bad++; $display("FAIL mid_no_done got=%0d exp=0", done_port_q.size() - b_done);
        end
        fork
            begin : t0
                bit e; logic [31:0] r; int l;
                @(negedge PCLK);
                port_req(0, 1'b0, 32'h10, 32'h0, 1'b0, e, r, l);
                n_cmp++; if (r !== ref_mem[4]) begin n_bad++; $display("FAIL tie_p0_rd got=%h exp=%h", r, ref_mem[4]); end
            end
            begin : t1
                bit e; logic [31:0] r; int l;
                @(negedge PCLK);
                port_req(1, 1'b0, 32'h04, 32'h0, 1'b0, e, r, l);
                n_cmp++; if (r !== ref_mem[1]) begin n_bad++; $display("FAIL tie_p1_rd got=%h exp=%h", r, ref_mem[1]); end
            end
        join
        #1;
        n_cmp++;
        if (done_port_q.size() - b_done !== 2 || done_port_q[b_done] !== 0) begin
            n_bad++; $display("FAIL tie_first_grant got n=%0d exp first port 0", done_port_q.size() - b_done);
        end
    endtask

    task automatic test_hold_valid();
        bit e; logic [31:0] r; int l; int b_en; int b_done; int got; int exp;
        @(negedge PCLK);
        b_en   = en_cyc_q.size();
        b_done = done_port_q.size();
        port_req(0, 1'b1, 32'h20, 32'h5A5A_1234, 1'b1, e, r, l);
        ref_mem[8] = 32'h5A5A_1234;
        @(negedge PCLK);
        port_req(0, 1'b0, 32'h20, 32'h0, 1'b0, e, r, l);
        #1;
        n_cmp++; if (r !== ref_mem[8]) begin n_bad++; $display("FAIL hold_rd got=%h exp=%h", r, ref_mem[8]); end
        n_cmp++; if (l !== 3) begin n_bad++; $display("FAIL hold_latency got=%0d exp=3", l); end
        n_cmp++;
        if (en_cyc_q.size() - b_en !== 2) begin
            n_bad++; $display("FAIL hold_strobes got=%0d exp=2", en_cyc_q.size() - b_en);
        end
        got = (b_en + 1 < en_cyc_q.size()) ? en_cyc_q[b_en + 1] : -1;
        exp = (b_done < done_cyc_q.size()) ? done_cyc_q[b_done] + 2 : -2;
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL hold_regrant_cycle got=%0d exp=%0d", got, exp); end
    endtask

    task automatic test_random();
        bit e; logic [31:0] r; int l;
        int p; bit wr; logic [31:0] a; logic [31:0] d; int kind; int idx; int dsel; int dly;
        bit legal; bit x_err; logic [31:0] x_rd; int x_lat;
        for (int i = 0; i < 40; i++) begin
            p    = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            d    = $urandom;
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            if (kind <= 7)      a = 32'(idx * 4);
            else if (kind == 8) a = 32'(idx * 4 + $urandom_range(1, 3));
            else                a = 32'(32'h40 + 4 * $urandom_range(0, 1000));
            dsel = $urandom_range(0, 9);
            dly  = (dsel <= 3) ? dsel : ((dsel == 9) ? NEVER : 0);
            legal = (a <= 32'h3C) && (a % 4 == 0);
            x_err = !legal || (dly == NEVER);
            x_rd  = (!x_err && !wr) ? ref_mem[a / 4] : 32'h0;
            x_lat = !legal ? 2 : ((dly == NEVER) ? T + 2 : 3 + dly);
            if (legal && wr) ref_mem[a / 4] = d;
            rf_delay = dly;
            @(negedge PCLK);
            port_req(p, wr, a, d, 1'b0, e, r, l);
            n_cmp++; if (e !== x_err) begin n_bad++; $display("FAIL rnd_err[%0d] p%0d a=%h got=%b exp=%b", i, p, a, e, x_err); end
            n_cmp++; if (r !== x_rd) begin n_bad++; $display("FAIL rnd_rdata[%0d] p%0d a=%h got=%h exp=%h", i, p, a, r, x_rd); end
            n_cmp++; if (l !== x_lat) begin n_bad++; $display("FAIL rnd_latency[%0d] p%0d a=%h got=%0d exp=%0d", i, p, a, l, x_lat); end
        end
        rf_delay = 0;
    endtask

    task automatic test_strobe_rules();
        #1;
        n_cmp++; if (en_consec !== 0) begin n_bad++; $display("FAIL enable_consecutive got=%0d exp=0", en_consec); end
        n_cmp++; if (done_both !== 0) begin n_bad++; $display("FAIL done_both_ports got=%0d exp=0", done_both); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_hold_valid();
        test_random();
        test_strobe_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
